seq_div: RTL
============

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal values are 2 to 32.
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 rst  input  1  reset, asynchronous and active-high; one clock only.
REQ-004 start  input  1  request to divide; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  numerator; captured on the accepting edge.
REQ-006 divisor  input  WIDTH  denominator; captured on the accepting edge.
REQ-007 busy  output  1  high while a division is in progress (RUN).
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 quotient  output  WIDTH  result quotient.
REQ-010 remainder  output  WIDTH  result remainder.
REQ-011 div_by_zero  output  1  flag set when the captured divisor is 0; valid with done.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, FINISH.
- IDLE->RUN on start with divisor!=0.
- IDLE->FINISH on start with divisor==0.
- RUN->FINISH after exactly WIDTH iterations.
- FINISH->IDLE unconditionally.
REQ-013 Each iteration SHALL be one restoring step: shift the partial remainder left by one and bring in the next dividend MSB, trial-subtract the divisor, keep the difference if it is non-negative, and shift the result bit into the quotient.
REQ-014 Latency: start accepted at edge N; done SHALL be high for exactly the cycle following edge N+WIDTH+1; divide-by-zero gives done after edge N+1.
REQ-015 busy SHALL be high exactly in RUN; done SHALL be high exactly in FINISH.
REQ-016 quotient, remainder and div_by_zero SHALL update only on entry to FINISH and hold until the next FINISH.
REQ-017 start while busy or done is high SHALL be ignored; no queuing.
REQ-018 Divide by zero SHALL give quotient all-ones, remainder = captured dividend and div_by_zero=1; otherwise div_by_zero=0.
REQ-019 A dividend of 0 SHALL run the full WIDTH iterations and give quotient 0, remainder 0.
REQ-020 Internal partial remainder SHALL be WIDTH+1 bits so the trial subtraction never overflows.

Reset
REQ-021 rst SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear all internal registers.
REQ-022 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts behaves as from power-up.

Configuration
REQ-023 Macro SEQ_DIV_SIGNED_EN defined: operands and results are two's complement.
- Magnitudes are divided.
- Quotient is negated if the operand signs differ.
- Remainder takes the sign of the dividend (truncation toward zero).
- Latency is unchanged.
- The most-negative/-1 case returns quotient = most-negative and remainder 0 (wrap).
- Divide-by-zero behaviour is unchanged.
REQ-024 Macro SEQ_DIV_SIGNED_EN undefined: all values are unsigned and no sign logic is synthesized.

Structure
REQ-025 Package seq_div_pkg SHALL hold the state enum typedef (IDLE, RUN, FINISH) and the default-WIDTH constant.
REQ-026 Sub-module div_step SHALL implement one combinational restoring iteration.
- Inputs: partial remainder, incoming bit, divisor.
- Outputs: next remainder, quotient bit.
- seq_div instantiates it once.

Verification (WIDTH=8)
REQ-027 Unsigned 100/7 -> quotient 14, remainder 2, done exactly 9 edges after the accepting edge, busy high for 8 cycles.
REQ-028 5/0 -> quotient 0xFF, remainder 5, div_by_zero=1, done one cycle after acceptance, busy never high.
REQ-029 start pulsed with 9/3 during RUN of 200/10 -> only one done, quotient 20, remainder 0; the second request is ignored.
REQ-030 rst asserted on the 4th RUN cycle of 255/1 -> all outputs 0 immediately, no done; a following 255/1 gives quotient 255, remainder 0.
REQ-031 With SEQ_DIV_SIGNED_EN: -100/7 -> quotient -14 (0xF2), remainder -2 (0xFE); -128/-1 -> quotient 0x80, remainder 0; 100/-7 -> quotient -14, remainder 2.
REQ-032 Back-to-back: start held high continuously -> a new division is accepted every WIDTH+2 cycles, each with a correct result.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

endpackage

// File: rtl/seq_div_step.sv
// div_step: one combinational restoring-division iteration.
// The shifted partial remainder is WIDTH+1 bits so the trial compare cannot overflow.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // Shift in the next dividend bit, trial-subtract, keep the difference when non-negative.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    // The kept result is always below divisor, so WIDTH-bit arithmetic is exact here.
    rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIV_SIGNED_EN selects two's-complement operands (truncating division).
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic             last_iter;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] mag_dvd, mag_dvs;
  logic [WIDTH-1:0] q_out, r_out;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (shift_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign quo_fin   = {shift_q[WIDTH-2:0], q_bit};

`ifdef SEQ_DIV_SIGNED_EN
  logic q_neg_q, r_neg_q;

  // Divide magnitudes; fix up signs of the final quotient and remainder.
  always_comb begin
    mag_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    mag_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_out   = q_neg_q ? -quo_fin : quo_fin;
    r_out   = r_neg_q ? -rem_nxt : rem_nxt;
  end

  // Operand signs captured at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (state_q == IDLE && start && divisor != '0) begin
      q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_q <= dividend[WIDTH-1];
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    mag_dvd = dividend;
    mag_dvs = divisor;
    q_out   = quo_fin;
    r_out   = rem_nxt;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (divisor == '0) ? FINISH : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands, iterate, and latch results on entry to FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q       <= '0;
      shift_q     <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              rem_q   <= '0;
              shift_q <= mag_dvd;
              dvs_q   <= mag_dvs;
              cnt_q   <= '0;
            end
          end
        end
        RUN: begin
          rem_q   <= rem_nxt;
          shift_q <= quo_fin;
          cnt_q   <= cnt_q + 1'b1;
          if (last_iter) begin
            quotient    <= q_out;
            remainder   <= r_out;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
